// File: rtl/hub_slot.sv
// hub_slot: round-robin hub memory sequencer with a two-stage grant/return pipeline.
// Optional HUB_SLOT_STEAL_EN hands an idle slot to the next waiting cog in rotation order.
module hub_slot #(
  parameter int unsigned COGS = 8
) (
  input  logic                      clk_cog,
  input  logic                      nres,
  input  logic                      ena_bus,
  input  logic [COGS-1:0]           req,
  input  logic [COGS-1:0]           cog_w,
  input  logic [4*COGS-1:0]         cog_wb,
  input  logic [14*COGS-1:0]        cog_a,
  input  logic [32*COGS-1:0]        cog_d,
  output logic                      mem_ena,
  output logic                      mem_w,
  output logic [3:0]                mem_wb,
  output logic [13:0]               mem_a,
  output logic [31:0]               mem_d,
  input  logic [31:0]               mem_q,
  output logic [COGS-1:0]           ack,
  output logic [31:0]               rdata,
  output logic [$clog2(COGS)-1:0]   slot
);

  localparam int unsigned SW = $clog2(COGS);

  logic [SW-1:0]   r_slot;
  logic            r_mem_valid;
  logic            r_mem_w;
  logic [3:0]      r_mem_wb;
  logic [13:0]     r_mem_a;
  logic [31:0]     r_mem_d;
  logic [COGS-1:0] r_pend;
  logic            r_s1_vld;
  logic [SW-1:0]   r_s1_own;
  logic            r_s2_vld;
  logic [SW-1:0]   r_s2_own;
  logic [COGS-1:0] r_ack;
  logic [31:0]     r_rdata;

  logic [COGS-1:0] w_avail;
  logic            w_gnt_vld;
  logic [SW-1:0]   w_gnt_own;
  logic [COGS-1:0] w_gnt_mask;
  logic [COGS-1:0] w_ret_mask;

  // pending is sampled pre-edge, so an ack and regrant of one cog never coincide
  assign w_avail = req & ~r_pend;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_own = r_slot;
`ifdef HUB_SLOT_STEAL_EN
    for (int unsigned i = 0; i < COGS; i++) begin
      if (!w_gnt_vld && w_avail[r_slot + SW'(i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_own = r_slot + SW'(i);
      end
    end
`else
    w_gnt_vld = w_avail[r_slot];
`endif
  end

  always_comb begin
    w_gnt_mask = '0;
    w_gnt_mask[w_gnt_own] = w_gnt_vld;
    w_ret_mask = '0;
    w_ret_mask[r_s2_own] = r_s2_vld;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      r_slot      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_w     <= 1'b0;
      r_mem_wb    <= '0;
      r_mem_a     <= '0;
      r_mem_d     <= '0;
      r_pend      <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_own    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_own    <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
    end else if (ena_bus) begin
      r_slot <= r_slot + SW'(1);
      if (w_gnt_vld) begin
        r_mem_valid <= 1'b1;
        r_mem_w     <= cog_w[w_gnt_own];
        r_mem_wb    <= cog_wb[4*w_gnt_own +: 4];
        r_mem_a     <= cog_a[14*w_gnt_own +: 14];
        r_mem_d     <= cog_d[32*w_gnt_own +: 32];
      end else begin
        r_mem_valid <= 1'b0;
        r_mem_w     <= 1'b0;
      end
      r_s1_vld <= w_gnt_vld;
      r_s1_own <= w_gnt_own;
      r_s2_vld <= r_s1_vld;
      r_s2_own <= r_s1_own;
      r_ack    <= w_ret_mask;
      if (r_s2_vld) begin
        r_rdata <= mem_q;
      end
      r_pend <= (r_pend | w_gnt_mask) & ~w_ret_mask;
    end
  end

  assign mem_ena = ena_bus & r_mem_valid;
  assign mem_w   = r_mem_w;
  assign mem_wb  = r_mem_wb;
  assign mem_a   = r_mem_a;
  assign mem_d   = r_mem_d;
  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign slot    = r_slot;

endmodule
